video_signal_generator: RTL and testbench
=========================================

Name: video_signal_generator

Overview:
- Free-running raster timing generator, clocked by the pixel clock.
- Produces horizontal and vertical screen coordinates, sync pulses, data-enable, a new-frame strobe and a frame counter.
- Sits at the front of the video pipeline; downstream overlay and pixel logic index off o_sx/o_sy.
- Defaults give 1280x720@60 (CEA-861, 1650x750 total).

Parameters:
- ACTIVE_H_PIXELS, 1280, visible pixels per line
- H_FRONT_PORCH, 110, pixels between end of active video and hsync start
- H_SYNCH_WIDTH, 40, hsync pulse length in pixels
- H_BACK_PORCH, 220, pixels between hsync end and line end
- ACTIVE_LINES, 720, visible lines per frame
- V_FRONT_PORCH, 5, lines between end of active video and vsync start
- V_SYNCH_WIDTH, 5, vsync pulse length in lines
- V_BACK_PORCH, 20, lines between vsync end and frame end
- FPS, 60, frame-counter modulus; must be >= 2
- H_SYNC_POL, 1, asserted level of o_hsync (1 = active-high)
- V_SYNC_POL, 1, asserted level of o_vsync
- Derived: H_TOTAL = sum of the four H parameters; V_TOTAL = sum of the four V parameters.

Ports:
- i_clk_pxl  in  1  pixel clock; all logic is on its rising edge
- i_reset_n  in  1  asynchronous, active-low reset
- o_sx  out  clog2(H_TOTAL)  current horizontal position
- o_sy  out  clog2(V_TOTAL)  current vertical position
- o_hsync  out  1  horizontal sync
- o_vsync  out  1  vertical sync
- o_de  out  1  data enable (active-video region)
- o_nf  out  1  new-frame strobe
- o_fc  out  clog2(FPS)  frame counter

Behaviour:
- Reset (asynchronous, while i_reset_n=0):
  - o_sx=0, o_sy=0, o_fc=0, o_nf=0.
  - o_hsync and o_vsync at their deasserted level (~POL).
  - o_de follows its decode rule, so it reads 1 at (0,0).
  - The block holds in this state for as long as reset is low.
- Horizontal counter: o_sx increments by 1 each clock. At H_TOTAL-1 it wraps to 0.
- Vertical counter: o_sy increments only on the cycle o_sx wraps. At V_TOTAL-1 (with o_sx = H_TOTAL-1) it wraps to 0.
- First cycle after reset release: the counters advance from (0,0) to (1,0). Pixel (0,0) is therefore presented during reset and on the release cycle.
- Frame counter: o_fc increments on each full-frame wrap (o_sx, o_sy) = (H_TOTAL-1, V_TOTAL-1) -> (0,0). After FPS-1 it wraps to 0.
- Combinational decodes of the registered counters (same cycle, zero latency):
  - o_de = (o_sx < ACTIVE_H_PIXELS) && (o_sy < ACTIVE_LINES).
  - o_hsync = POL when ACTIVE_H_PIXELS+H_FRONT_PORCH <= o_sx < ACTIVE_H_PIXELS+H_FRONT_PORCH+H_SYNCH_WIDTH; otherwise ~POL.
  - o_vsync = POL when ACTIVE_LINES+V_FRONT_PORCH <= o_sy < ACTIVE_LINES+V_FRONT_PORCH+V_SYNCH_WIDTH; otherwise ~POL. This is line-based and aligned to the o_sx=0 boundary.
- o_nf (registered):
  - High for exactly one clock: the cycle in which the counters present (0,0) as the result of a frame wrap.
  - Not asserted on reset release or while reset is held.
  - Asserted in the same cycle that o_fc shows its new value.
- Mid-frame reset: counters, o_fc and o_nf return to reset values immediately, without waiting for a clock edge.
- All counters use unsigned arithmetic. No output ever exceeds its range: o_sx <= H_TOTAL-1, o_sy <= V_TOTAL-1, o_fc <= FPS-1.

Test Plan:
- Reset then release, defaults -> during reset sx=0, sy=0, de=1, hsync=vsync=0, nf=0, fc=0. One clock after release: sx=1, sy=0.
- Run one line -> de=1 for sx 0..1279 and 0 from 1280. hsync=1 exactly for sx 1390..1429 (40 cycles). sx wraps 1649->0 with sy 0->1.
- Run one frame -> de=0 for sy>=720. vsync=1 for sy 725..729, spanning 5*1650 = 8250 cycles. After 1,237,500 cycles from (0,0): sx=0, sy=0, nf=1 for one cycle, fc=1.
- Run 60 frames -> fc counts 0..59 and then returns to 0. nf pulses exactly 60 times.
- Assert i_reset_n=0 mid-line (e.g. sx=500, sy=300) without a clock edge -> outputs return to reset values immediately. After release, counting restarts from 0 with no nf pulse.
- Small-parameter instance (ACTIVE_H=4, HFP=1, HSW=1, HBP=1, ACTIVE_V=2, VFP=1, VSW=1, VBP=1, FPS=2) -> exhaustive cycle-by-cycle compare against the decode equations over 3 frames.

Source files
------------

// File: rtl/video_signal_generator.sv
// Free-running raster timing generator: pixel/line counters, sync and
// data-enable decodes, new-frame strobe and a modulo-FPS frame counter.
module video_signal_generator #(
  parameter int unsigned ACTIVE_H_PIXELS = 1280,
  parameter int unsigned H_FRONT_PORCH   = 110,
  parameter int unsigned H_SYNCH_WIDTH   = 40,
  parameter int unsigned H_BACK_PORCH    = 220,
  parameter int unsigned ACTIVE_LINES    = 720,
  parameter int unsigned V_FRONT_PORCH   = 5,
  parameter int unsigned V_SYNCH_WIDTH   = 5,
  parameter int unsigned V_BACK_PORCH    = 20,
  parameter int unsigned FPS             = 60,
  parameter int unsigned H_SYNC_POL      = 1,
  parameter int unsigned V_SYNC_POL      = 1,
  localparam int unsigned H_TOTAL = ACTIVE_H_PIXELS + H_FRONT_PORCH + H_SYNCH_WIDTH + H_BACK_PORCH,
  localparam int unsigned V_TOTAL = ACTIVE_LINES + V_FRONT_PORCH + V_SYNCH_WIDTH + V_BACK_PORCH,
  localparam int unsigned SX_W    = $clog2(H_TOTAL),
  localparam int unsigned SY_W    = $clog2(V_TOTAL),
  localparam int unsigned FC_W    = $clog2(FPS)
) (
  input  logic            i_clk_pxl,
  input  logic            i_reset_n,
  output logic [SX_W-1:0] o_sx,
  output logic [SY_W-1:0] o_sy,
  output logic            o_hsync,
  output logic            o_vsync,
  output logic            o_de,
  output logic            o_nf,
  output logic [FC_W-1:0] o_fc
);

  localparam int unsigned HS_START = ACTIVE_H_PIXELS + H_FRONT_PORCH;
  localparam int unsigned HS_END   = HS_START + H_SYNCH_WIDTH;
  localparam int unsigned VS_START = ACTIVE_LINES + V_FRONT_PORCH;
  localparam int unsigned VS_END   = VS_START + V_SYNCH_WIDTH;
  localparam logic        H_POL    = 1'(H_SYNC_POL);
  localparam logic        V_POL    = 1'(V_SYNC_POL);

  logic [SX_W-1:0] r_sx;
  logic [SY_W-1:0] r_sy;
  logic [FC_W-1:0] r_fc;
  logic            r_nf;

  logic        w_h_end;
  logic        w_v_end;
  logic        w_frame_end;
  logic        w_fc_end;
  logic [31:0] w_sx32;
  logic [31:0] w_sy32;
  logic        w_in_hs;
  logic        w_in_vs;

  assign w_h_end     = (r_sx == SX_W'(H_TOTAL - 1));
  assign w_v_end     = (r_sy == SY_W'(V_TOTAL - 1));
  assign w_frame_end = w_h_end && w_v_end;
  assign w_fc_end    = (r_fc == FC_W'(FPS - 1));

  // Horizontal position: wraps at end of line
  always_ff @(posedge i_clk_pxl or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sx <= '0;
    end else if (w_h_end) begin
      r_sx <= '0;
    end else begin
      r_sx <= r_sx + SX_W'(1);
    end
  end

  // Vertical position: advances only on line wrap, wraps at end of frame
  always_ff @(posedge i_clk_pxl or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sy <= '0;
    end else if (w_h_end) begin
      if (w_v_end) begin
        r_sy <= '0;
      end else begin
        r_sy <= r_sy + SY_W'(1);
      end
    end
  end

  // Frame counter and new-frame strobe, both updated on the frame wrap edge
  always_ff @(posedge i_clk_pxl or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_fc <= '0;
      r_nf <= 1'b0;
    end else begin
      r_nf <= w_frame_end;
      if (w_frame_end) begin
        r_fc <= w_fc_end ? '0 : r_fc + FC_W'(1);
      end
    end
  end

  // Zero-latency decodes of the registered position
  assign w_sx32  = 32'(r_sx);
  assign w_sy32  = 32'(r_sy);
  assign w_in_hs = (w_sx32 >= HS_START) && (w_sx32 < HS_END);
  assign w_in_vs = (w_sy32 >= VS_START) && (w_sy32 < VS_END);

  assign o_sx    = r_sx;
  assign o_sy    = r_sy;
  assign o_fc    = r_fc;
  assign o_nf    = r_nf;
  assign o_de    = (w_sx32 < ACTIVE_H_PIXELS) && (w_sy32 < ACTIVE_LINES);
  assign o_hsync = w_in_hs ? H_POL : ~H_POL;
  assign o_vsync = w_in_vs ? V_POL : ~V_POL;

endmodule

// File: tb/tb_video_signal_generator.sv
// Bench for video_signal_generator: a small-parameter instance (inverted
// hsync polarity) and a default 720p instance, both compared every cycle
// against a closed-form model driven by the cycle count since reset release.
module tb_video_signal_generator;

  logic clk;
  logic rst_n;

  // Small instance: HT=7, VT=5, FPS=2, hsync active-low
  logic [2:0] s_sx;
  logic [2:0] s_sy;
  logic       s_hs, s_vs, s_de, s_nf;
  logic [0:0] s_fc;

  // Default instance: HT=1650, VT=750, FPS=60
  logic [10:0] d_sx;
  logic [9:0]  d_sy;
  logic        d_hs, d_vs, d_de, d_nf;
  logic [5:0]  d_fc;

  int unsigned n_pass;
  int unsigned n_total;
  int unsigned n_cyc;
  int unsigned nf_seen;

  video_signal_generator #(
    .ACTIVE_H_PIXELS(4), .H_FRONT_PORCH(1), .H_SYNCH_WIDTH(1), .H_BACK_PORCH(1),
    .ACTIVE_LINES(2), .V_FRONT_PORCH(1), .V_SYNCH_WIDTH(1), .V_BACK_PORCH(1),
    .FPS(2), .H_SYNC_POL(0), .V_SYNC_POL(1)
  ) u_small (
    .i_clk_pxl(clk), .i_reset_n(rst_n),
    .o_sx(s_sx), .o_sy(s_sy), .o_hsync(s_hs), .o_vsync(s_vs),
    .o_de(s_de), .o_nf(s_nf), .o_fc(s_fc)
  );

  video_signal_generator u_def (
    .i_clk_pxl(clk), .i_reset_n(rst_n),
    .o_sx(d_sx), .o_sy(d_sy), .o_hsync(d_hs), .o_vsync(d_vs),
    .o_de(d_de), .o_nf(d_nf), .o_fc(d_fc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
  endtask

  // Expected outputs derived purely from the number of clocks since release
  task automatic check_inst(
    input string who, input int unsigned n,
    input int unsigned ah, input int unsigned hfp, input int unsigned hsw, input int unsigned hbp,
    input int unsigned av, input int unsigned vfp, input int unsigned vsw, input int unsigned vbp,
    input int unsigned fps, input bit hpol, input bit vpol,
    input int unsigned sx, input int unsigned sy, input int unsigned fc,
    input bit hs, input bit vs, input bit de, input bit nf);
    int unsigned ht, vt, ft, e_sx, e_sy, e_fc;
    bit e_nf, e_de, e_hs, e_vs;
    ht   = ah + hfp + hsw + hbp;
    vt   = av + vfp + vsw + vbp;
    ft   = ht * vt;
    e_sx = n % ht;
    e_sy = (n / ht) % vt;
    e_fc = (n / ft) % fps;
    e_nf = (n != 0) && (n % ft == 0);
    e_de = (e_sx < ah) && (e_sy < av);
    e_hs = (e_sx >= ah + hfp && e_sx < ah + hfp + hsw) ? hpol : !hpol;
    e_vs = (e_sy >= av + vfp && e_sy < av + vfp + vsw) ? vpol : !vpol;
    chk({who, ".sx"},    sx, e_sx);
    chk({who, ".sy"},    sy, e_sy);
    chk({who, ".fc"},    fc, e_fc);
    chk({who, ".nf"},    32'(nf), 32'(e_nf));
    chk({who, ".de"},    32'(de), 32'(e_de));
    chk({who, ".hsync"}, 32'(hs), 32'(e_hs));
    chk({who, ".vsync"}, 32'(vs), 32'(e_vs));
  endtask

  task automatic check_both(input int unsigned n);
    check_inst("small", n, 4, 1, 1, 1, 2, 1, 1, 1, 2, 1'b0, 1'b1,
               32'(s_sx), 32'(s_sy), 32'(s_fc), s_hs, s_vs, s_de, s_nf);
    check_inst("dflt", n, 1280, 110, 40, 220, 720, 5, 5, 20, 60, 1'b1, 1'b1,
               32'(d_sx), 32'(d_sy), 32'(d_fc), d_hs, d_vs, d_de, d_nf);
  endtask

  // Advance k clocks, checking every cycle and counting small-instance nf pulses
  task automatic run_cycles(input int unsigned k);
    for (int i = 0; i < int'(k); i++) begin
      @(negedge clk);
      n_cyc++;
      if (s_nf) nf_seen++;
      check_both(n_cyc);
    end
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    n_cyc   = 0;
    nf_seen = 0;
    rst_n   = 1'b0;

    // Held reset: outputs at reset values, de=1 at (0,0), syncs deasserted
    repeat (3) begin
      @(negedge clk);
      check_both(0);
    end

    // Release on a negedge; first posedge moves to (1,0)
    rst_n = 1'b1;
    check_both(0);
    run_cycles(1);
    chk("dflt.first_sx", 32'(d_sx), 32'd1);

    // Two full default lines; covers many small frames and fc wrap
    run_cycles(2 * 1650 + 9);
    chk("small.nf_count", nf_seen, n_cyc / 35);

    // Random asynchronous mid-frame resets, then restart from (0,0)
    for (int r = 0; r < 3; r++) begin
      run_cycles($urandom_range(40, 400));
      #2;
      rst_n = 1'b0;
      #1;
      n_cyc = 0;
      check_both(0);
      repeat ($urandom_range(1, 4)) begin
        @(negedge clk);
        check_both(0);
      end
      rst_n   = 1'b1;
      nf_seen = 0;
      run_cycles($urandom_range(80, 300));
      chk("small.nf_count_restart", nf_seen, n_cyc / 35);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
